// File: rtl/axis_frame_packer.sv
// rtl/axis_frame_packer.sv - packs RATIO narrow R-channel beats into one AXI-Stream pixel group
// Optional burst-end check enabled by defining AXIS_FRAME_PACKER_RLAST_CHECK_EN.
module axis_frame_packer #(
    parameter int IN_DATA_W     = 64,
    parameter int OUT_DATA_W    = 256,
    parameter int AXIS_TID_W    = 2,
    parameter int AXIS_TDEST_W  = 1,
    parameter int TDEST_VAL     = 1,
    parameter int FRAME_GRP_NUM = 4800
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_DATA_W-1:0]      s_rdata_i,
    input  logic                      s_rlast_i,
    input  logic                      s_rvalid_i,
    output logic                      s_rready_o,
    output logic [AXIS_TID_W-1:0]     m_tid_o,
    output logic [AXIS_TDEST_W-1:0]   m_tdest_o,
    output logic [OUT_DATA_W-1:0]     m_tdata_o,
    output logic [OUT_DATA_W/8-1:0]   m_tkeep_o,
    output logic [OUT_DATA_W/8-1:0]   m_tstrb_o,
    output logic                      m_tlast_o,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      frame_done_o,
    output logic                      err_o
);

    localparam int RATIO = OUT_DATA_W / IN_DATA_W;
    localparam int BCW   = $clog2(RATIO);
    localparam int GCW   = $clog2(FRAME_GRP_NUM + 1);

    logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [GCW-1:0]          grp_cnt_q, grp_cnt_d;
    logic [AXIS_TID_W-1:0]   frame_tid_q, frame_tid_d;
    logic [OUT_DATA_W-1:0]   pack_q, pack_d;
    logic [OUT_DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic [AXIS_TID_W-1:0]   m_tid_q, m_tid_d;
    logic                    m_tlast_q, m_tlast_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    frame_done_q, frame_done_d;

    logic beat_acc;
    logic beat_last;
    logic grp_done;
    logic grp_last;
    logic out_hs;

    assign beat_last  = (beat_cnt_q == BCW'(RATIO - 1));
    assign s_rready_o = ~beat_last | ~m_tvalid_q | m_tready_i;
    assign beat_acc   = s_rvalid_i & s_rready_o;
    assign grp_done   = beat_acc & beat_last;
    assign grp_last   = (grp_cnt_q == GCW'(FRAME_GRP_NUM - 1));
    assign out_hs     = m_tvalid_q & m_tready_i;

    // grp_cnt_q/frame_tid_q index the next group to be loaded; since the output
    // register holds a single group, this stays in step with delivered groups.
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        frame_tid_d  = frame_tid_q;
        pack_d       = pack_q;
        m_tdata_d    = m_tdata_q;
        m_tid_d      = m_tid_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        frame_done_d = out_hs & m_tlast_q;

        if (beat_acc) begin
            pack_d[beat_cnt_q*IN_DATA_W +: IN_DATA_W] = s_rdata_i;
            beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
        end

        if (grp_done) begin
            m_tdata_d  = pack_d;
            m_tid_d    = frame_tid_q;
            m_tlast_d  = grp_last;
            m_tvalid_d = 1'b1;
            if (grp_last) begin
                grp_cnt_d   = '0;
                frame_tid_d = frame_tid_q + 1'b1;
            end else begin
                grp_cnt_d = grp_cnt_q + 1'b1;
            end
        end else if (out_hs) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q   <= '0;
            grp_cnt_q    <= '0;
            frame_tid_q  <= '0;
            pack_q       <= '0;
            m_tdata_q    <= '0;
            m_tid_q      <= '0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            frame_tid_q  <= frame_tid_d;
            pack_q       <= pack_d;
            m_tdata_q    <= m_tdata_d;
            m_tid_q      <= m_tid_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef AXIS_FRAME_PACKER_RLAST_CHECK_EN
    logic err_q, err_d;

    // A burst ending anywhere but on the final beat of a group is a DMA fault.
    always_comb begin
        err_d = err_q | (beat_acc & s_rlast_i & ~beat_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_rlast;
    assign unused_rlast = s_rlast_i;
    assign err_o        = 1'b0;
`endif

    assign m_tid_o      = m_tid_q;
    assign m_tdest_o    = AXIS_TDEST_W'(TDEST_VAL);
    assign m_tdata_o    = m_tdata_q;
    assign m_tkeep_o    = '1;
    assign m_tstrb_o    = '1;
    assign m_tlast_o    = m_tlast_q;
    assign m_tvalid_o   = m_tvalid_q;
    assign frame_done_o = frame_done_q;

endmodule
